// File: rtl/mult_mulh_unit_if.sv
// EX-stage multiplier port: request fields from the decoder, result and stall back to EX.
interface mult_mulh_unit_if;
  logic        enable_i;
  logic [2:0]  operator_i;
  logic [1:0]  short_signed_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        ex_ready_i;
  logic [31:0] result_o;
  logic        ready_o;
  logic        mulh_active_o;

  modport master (
    output enable_i, operator_i, short_signed_i, op_a_i, op_b_i, ex_ready_i,
    input  result_o, ready_o, mulh_active_o
  );

  modport slave (
    input  enable_i, operator_i, short_signed_i, op_a_i, op_b_i, ex_ready_i,
    output result_o, ready_o, mulh_active_o
  );
endinterface

// File: rtl/mult_mulh_unit.sv
// RV32M multiply unit: single-cycle MUL low word, four-step 17x17 partial-product
// sequence for MULH/MULHSU/MULHU high word.
module mult_mulh_unit (
  input logic             clk,
  input logic             rst_n,
  mult_mulh_unit_if.slave bus
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned ACC_W  = 34;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PP0  = 3'd1;
  localparam logic [2:0] PP1  = 3'd2;
  localparam logic [2:0] PP2  = 3'd3;
  localparam logic [2:0] PP3  = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  localparam logic [2:0] MUL_MAC32 = 3'b000;
  localparam logic [2:0] MUL_H     = 3'b110;

  logic [2:0]              state_q, state_d;
  logic [DATA_W-1:0]       a_q, b_q;
  logic [1:0]              sgn_q;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    latch_en;
  logic signed [HALF_W:0]  mul_a, mul_b;
  logic signed [ACC_W-1:0] pp;
  logic [DATA_W-1:0]       mul_lo;

  // Half-operand selection; low halves zero-extend, high halves follow operand signedness
  always_comb begin
    mul_a = {1'b0, a_q[HALF_W-1:0]};
    mul_b = {1'b0, b_q[HALF_W-1:0]};
    case (state_q)
      PP1: mul_b = {sgn_q[1] & b_q[DATA_W-1], b_q[DATA_W-1:HALF_W]};
      PP2: mul_a = {sgn_q[0] & a_q[DATA_W-1], a_q[DATA_W-1:HALF_W]};
      PP3: begin
        mul_a = {sgn_q[0] & a_q[DATA_W-1], a_q[DATA_W-1:HALF_W]};
        mul_b = {sgn_q[1] & b_q[DATA_W-1], b_q[DATA_W-1:HALF_W]};
      end
      default: ;
    endcase
  end

  assign pp     = ACC_W'(mul_a) * ACC_W'(mul_b);
  assign mul_lo = bus.op_a_i * bus.op_b_i;

  assign bus.mulh_active_o = (state_q != IDLE);

  // Next state, accumulator update and outputs. The accumulator drops 16 settled
  // low bits before each higher-weight term so 34 bits suffice for product[63:32].
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    latch_en     = 1'b0;
    bus.result_o = '0;
    bus.ready_o  = 1'b1;
    case (state_q)
      IDLE: begin
        if (bus.enable_i) begin
          if (bus.operator_i == MUL_MAC32) begin
            bus.result_o = mul_lo;
          end else if (bus.operator_i == MUL_H) begin
            latch_en    = 1'b1;
            acc_d       = '0;
            bus.ready_o = 1'b0;
            state_d     = PP0;
          end
        end
      end
      PP0: begin
        bus.ready_o = 1'b0;
        acc_d       = pp;
        state_d     = PP1;
      end
      PP1: begin
        bus.ready_o = 1'b0;
        acc_d       = (acc_q >>> HALF_W) + pp;
        state_d     = PP2;
      end
      PP2: begin
        bus.ready_o = 1'b0;
        acc_d       = acc_q + pp;
        state_d     = PP3;
      end
      PP3: begin
        bus.ready_o = 1'b0;
        acc_d       = (acc_q >>> HALF_W) + pp;
        state_d     = DONE;
      end
      DONE: begin
        bus.result_o = acc_q[DATA_W-1:0];
        if (bus.ex_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      if (latch_en) begin
        a_q   <= bus.op_a_i;
        b_q   <= bus.op_b_i;
        sgn_q <= bus.short_signed_i;
      end
    end
  end
endmodule

// File: tb/tb_mult_mulh_unit.sv
// Scoreboard bench for mult_mulh_unit: directed RV32M cases plus randomized
// MUL / unsupported / MULH* traffic against an arithmetic reference model.
module tb_mult_mulh_unit;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mult_mulh_unit_if bus();
  mult_mulh_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    return p[31:0];
  endfunction

  // High word of the exact product; 64-bit wraparound keeps bits [63:32] exact
  function automatic logic [31:0] model_mulh(input logic [31:0] a, input logic [31:0] b,
                                             input logic [1:0] ss);
    logic [63:0] ea, eb, p;
    ea = ss[0] ? {{32{a[31]}}, a} : {32'b0, a};
    eb = ss[1] ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return p[63:32];
  endfunction

  // Monitor: one response per handshake (ready && ex_ready) while a request is visible
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.ready_o && bus.ex_ready_i && (bus.enable_i || bus.mulh_active_o)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL monitor_unexpected: got 0x%08h expected no response", bus.result_o);
        end else begin
          check("monitor_result", bus.result_o, exp_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.enable_i       = 1'b0;
    bus.operator_i     = 3'b000;
    bus.short_signed_i = 2'b00;
    bus.op_a_i         = $urandom;
    bus.op_b_i         = $urandom;
    bus.ex_ready_i     = 1'b1;
  endtask

  task automatic drive_noise(input logic exr);
    bus.enable_i       = 1'($urandom_range(0, 1));
    bus.operator_i     = ($urandom_range(0, 1) != 0) ? 3'b110 : 3'b000;
    bus.short_signed_i = 2'($urandom_range(0, 3));
    bus.op_a_i         = $urandom;
    bus.op_b_i         = $urandom;
    bus.ex_ready_i     = exr;
  endtask

  task automatic do_mul(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    step();
    bus.enable_i       = 1'b1;
    bus.operator_i     = op;
    bus.short_signed_i = 2'($urandom_range(0, 3));
    bus.op_a_i         = a;
    bus.op_b_i         = b;
    bus.ex_ready_i     = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    check("mul_ready", 32'(bus.ready_o), 32'd1);
    check("mul_active", 32'(bus.mulh_active_o), 32'd0);
  endtask

  task automatic do_mulh(input logic [31:0] a, input logic [31:0] b, input logic [1:0] ss,
                         input logic [31:0] exp, input int stall);
    int lows;
    step();
    bus.enable_i       = 1'b1;
    bus.operator_i     = 3'b110;
    bus.short_signed_i = ss;
    bus.op_a_i         = a;
    bus.op_b_i         = b;
    bus.ex_ready_i     = 1'($urandom_range(0, 1));
    exp_q.push_back(exp);
    @(negedge clk);
    check("mulh_accept_active", 32'(bus.mulh_active_o), 32'd0);
    lows = 0;
    for (int c = 0; c < 20 && !bus.ready_o; c++) begin
      lows++;
      step();
      drive_noise(1'b0);
      @(negedge clk);
      if (!bus.ready_o) check("mulh_pp_active", 32'(bus.mulh_active_o), 32'd1);
    end
    check("mulh_ready_low_cycles", 32'(lows), 32'd5);
    check("mulh_done_active", 32'(bus.mulh_active_o), 32'd1);
    check("mulh_done_result", bus.result_o, exp);
    for (int s = 0; s < stall; s++) begin
      step();
      drive_noise(1'b0);
      @(negedge clk);
      check("mulh_stall_ready", 32'(bus.ready_o), 32'd1);
      check("mulh_stall_result", bus.result_o, exp);
    end
    step();
    drive_idle();
    @(negedge clk);
    step();
    @(negedge clk);
    check("mulh_release_active", 32'(bus.mulh_active_o), 32'd0);
    check("mulh_release_ready", 32'(bus.ready_o), 32'd1);
    check("mulh_release_result", bus.result_o, 32'd0);
  endtask

  task automatic reset_mid_op();
    step();
    bus.enable_i       = 1'b1;
    bus.operator_i     = 3'b110;
    bus.short_signed_i = 2'b11;
    bus.op_a_i         = 32'h1234_5678;
    bus.op_b_i         = 32'h9abc_def0;
    bus.ex_ready_i     = 1'b0;
    step();
    drive_noise(1'b0);
    step();
    drive_noise(1'b0);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive_idle();
    @(negedge clk);
    check("rst_mid_ready", 32'(bus.ready_o), 32'd1);
    check("rst_mid_active", 32'(bus.mulh_active_o), 32'd0);
    check("rst_mid_result", bus.result_o, 32'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic [2:0]  op;
    logic [1:0]  ss;
    rst_n = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready", 32'(bus.ready_o), 32'd1);
    check("reset_active", 32'(bus.mulh_active_o), 32'd0);
    check("reset_result", bus.result_o, 32'd0);

    do_mul(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    do_mulh(32'h8000_0000, 32'h8000_0000, 2'b11, 32'h4000_0000, 0);
    do_mulh(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 32'h0000_0000, 3);
    do_mulh(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'hFFFF_FFFE, 0);
    do_mulh(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 32'hFFFF_FFFF, 1);
    do_mulh(32'h0000_0002, 32'h8000_0000, 2'b10, 32'hFFFF_FFFF, 0);
    do_mul(3'b001, 32'h1234_5678, 32'h0000_0010, 32'h0000_0000);
    step();
    drive_idle();
    @(negedge clk);
    check("unsupported_stays_idle", 32'(bus.mulh_active_o), 32'd0);
    check("idle_result_zero", bus.result_o, 32'd0);

    reset_mid_op();
    do_mulh(32'h8000_0000, 32'h8000_0000, 2'b11, 32'h4000_0000, 0);

    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 2))
        0: do_mul(3'b000, a, b, model_mul(a, b));
        1: begin
          op = 3'($urandom_range(0, 7));
          if (op == 3'b000 || op == 3'b110) op = 3'b111;
          do_mul(op, a, b, 32'd0);
        end
        default: begin
          ss = 2'($urandom_range(0, 3));
          do_mulh(a, b, ss, model_mulh(a, b, ss), int'($urandom_range(0, 3)));
        end
      endcase
    end

    step();
    drive_idle();
    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
